// File: rtl/rr_stream_mux_pkg.sv
// Shared defaults for the round-robin stream mux family.
// No types live here; channel-index width is derived inside each module.
// Kept separate so a future demux can pick up the same defaults.
package rr_stream_mux_pkg;
   localparam int RR_WIDTH_DEF = 8;
   localparam int RR_N_CH_DEF  = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant with its own load condition.
module rr_arbiter #(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] ptr,
   output logic [N_CH-1:0]         grant,
   output logic [$clog2(N_CH)-1:0] g,
   output logic                    any
);
   localparam int SEL_W = $clog2(N_CH);

   logic [N_CH-1:0] rot;
   int              off;
   int              idx;

   // Doubling the request vector turns the rotate into a plain right shift.
   assign rot = N_CH'({req, req} >> ptr);

   always_comb begin
      off   = 0;
      any   = 1'b0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (rot[j]) begin
            off = j;
            any = 1'b1;
         end
      end
      idx = int'(ptr) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      g     = SEL_W'(idx);
      grant = '0;
      if (any) grant[g] = 1'b1;
   end
endmodule

// File: rtl/rr_stream_mux.sv
// N-channel round-robin stream mux with optional packet locking and a registered output.
// Latency: one cycle from input transfer to out_valid.
// Backpressure: in_ready is all-zero while the output register holds an unaccepted beat.
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter  int WIDTH = RR_WIDTH_DEF,
   parameter  int N_CH  = RR_N_CH_DEF,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        lock_en,
   input  logic [N_CH-1:0]             in_valid,
   output logic [N_CH-1:0]             in_ready,
   input  logic [N_CH-1:0][WIDTH-1:0]  in_data,
   input  logic [N_CH-1:0]             in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_last,
   output logic [SEL_W-1:0]            out_sel
);
   logic              load;
   logic              any;
   logic              xfer;
   logic              locked;
   logic [SEL_W-1:0]  ptr;
   logic [SEL_W-1:0]  lock_ch;
   logic [SEL_W-1:0]  g;
   logic [N_CH-1:0]   lock_mask;
   logic [N_CH-1:0]   req;
   logic [N_CH-1:0]   grant;

   assign load = !out_valid || out_ready;

   always_comb begin
      lock_mask          = '0;
      lock_mask[lock_ch] = 1'b1;
   end

   // A locked channel that drops valid stalls the mux rather than letting others interleave.
   assign req = (locked && lock_en) ? (in_valid & lock_mask) : in_valid;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .g     (g),
      .any   (any)
   );

   assign in_ready = {N_CH{load}} & grant;
   assign xfer     = load && any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
         ptr       <= '0;
         locked    <= 1'b0;
         lock_ch   <= '0;
      end else begin
         if (load) begin
            out_valid <= any;
            if (any) begin
               out_data <= in_data[g];
               out_last <= in_last[g];
               out_sel  <= g;
            end
         end
         if (xfer && (!lock_en || in_last[g]))
            ptr <= (g == SEL_W'(N_CH - 1)) ? '0 : g + SEL_W'(1);
         if (!lock_en) begin
            locked <= 1'b0;
         end else if (xfer) begin
            locked <= !in_last[g];
            if (!in_last[g]) lock_ch <= g;
         end
      end
   end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes, round-robin arbitration and optional packet locking. It generalises the fixed 4:1 select-driven data mux: the select is generated internally by a fair arbiter, and the result is registered. It sits between several producer streams and one consumer, e.g. merging per-lane results onto a shared bus.

## Interface
- `WIDTH`, 8: data width per channel, ≥1.
- `N_CH`, 4: number of input channels, ≥2.
- `SEL_W`, `$clog2(N_CH)`: width of the channel index. Derived; not overridden.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lock_en`  in  1  1 = packet mode (grant held until `in_last`), 0 = per-beat round-robin.
- `in_valid`  in  N_CH  per-channel valid.
- `in_ready`  out  N_CH  per-channel ready.
- `in_data`  in  [N_CH-1:0][WIDTH-1:0]  per-channel data, packed.
- `in_last`  in  N_CH  per-channel end-of-packet.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  WIDTH  registered data.
- `out_last`  out  1  registered `in_last` of the beat.
- `out_sel`  out  SEL_W  index of the channel the beat came from.

## Operation
- `load = !out_valid || out_ready`. The output register can take a beat this cycle.
- Eligible set:
  - If `locked && lock_en`: only `lock_ch`.
  - Otherwise: all channels with `in_valid`.
- Grant: the first eligible channel scanning `ptr, ptr+1, …` modulo N_CH. At most one grant per cycle, one-hot.
- `in_ready[i] = load && grant[i]`. `in_ready` is combinational from `out_ready`, `out_valid`, all `in_valid` and state. No channel is ready while no beat is granted.
- On transfer (`in_valid[g] && in_ready[g]`), the register captures:
  - `out_data <= in_data[g]`
  - `out_last <= in_last[g]`
  - `out_sel <= g`
  - `out_valid <= 1`
- If `load` is high and no transfer occurs, `out_valid <= 0`. `out_data`, `out_last` and `out_sel` keep their values.
- Pointer: on a transfer with `!lock_en || in_last[g]`, `ptr <= (g+1) mod N_CH`. Otherwise `ptr` is unchanged.
- Lock state:
  - Transfer with `lock_en && !in_last[g]`: `locked <= 1`, `lock_ch <= g`.
  - Transfer with `in_last[g]`: `locked <= 0`.
  - `lock_en == 0` in any cycle: `locked <= 0`. The lock is released immediately, and arbitration in that cycle is already unlocked.
- Locked channel with `in_valid` low: no grant, output drains. Other channels are not served; the packet must not be interleaved.
- `out_valid && !out_ready`: `out_data`, `out_last` and `out_sel` stay stable, and all `in_ready` are 0.

## Timing
- Reset (async assert, sync-safe release):
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `out_sel = 0`.
  - `ptr = 0`, `locked = 0`, `lock_ch = 0`.
- Latency: input transfer at edge k gives `out_valid` high after edge k, visible in cycle k+1.
- Throughput: one beat per cycle when `out_ready` is held high.
- Reset mid-packet clears the lock and drops any held beat. The first post-reset grant goes to the lowest valid channel.
- Wrap-around: with `ptr = N_CH-1`, channel N_CH-1 is served before 0.
- Fairness: with all channels continuously valid and `lock_en = 0`, grants cycle 0,1,…,N_CH-1,0,…

## Structure
- Package `rr_stream_mux_pkg` holds no types. `SEL_W` is derived locally, so no package is needed unless shared with a future demux.
- One natural sub-module, `rr_arbiter`. It is combinational: `req[N_CH]`, `ptr` in; one-hot `grant`, index `g` and `any` out. It is implemented as a double-width rotate-and-priority-encode.
- The top level holds `ptr`, the lock state and the output register.

## Test plan
- Reset with all `in_valid = 4'b1111`, `out_ready = 1`, `lock_en = 0` → `out_sel` sequence 0,1,2,3,0 on consecutive cycles. `out_valid` stays high from the first cycle after the first transfer.
- Only ch2 valid with `in_data = 8'hA5`, `out_ready = 1` → `out_data = 8'hA5`, `out_sel = 2` one cycle later. `in_ready = 4'b0100`.
- Backpressure: `out_ready = 0` for 3 cycles while holding a beat → `out_data`/`out_sel` unchanged and `in_ready = 0` throughout. Release gives the next beat the following cycle.
- Lock mode, ch1 sends 3 beats (`last` on the 3rd) while ch0, ch3 are valid → `out_sel` = 1,1,1, then 3, then 0.
- Lock mode, ch1 mid-packet deasserts `in_valid` for 2 cycles while ch0 is valid → no ch0 grant and `out_valid` drops. Then `lock_en` goes to 0 → ch0 is granted the same cycle.
- Assert `rst_n = 0` asynchronously mid-packet with `out_valid = 1` → `out_valid`, `out_sel`, `out_data` are 0 immediately. After release, ch0 wins over ch3.
